// File: rtl/audio_pkg.sv
// Shared audio widths, saturation limits and the 16-bit sample type.
package audio_pkg;
  localparam int SAMPLE_W = 16;
  localparam int MIX_W    = 19;
  localparam int CODEC_W  = 32;

  localparam logic [SAMPLE_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [SAMPLE_W-1:0] SAT_MIN = 16'h8000;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/sample_fifo.sv
// Small synchronous sample FIFO: registered pointers/count, head visible
// combinationally on dout. A push into a full FIFO is accepted only when a
// pop happens in the same cycle; a pop of an empty FIFO is ignored.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic    CLOCK_50,
  input  logic    resetn,
  input  logic    push,
  input  logic    pop,
  input  sample_t din,
  output sample_t dout,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);

  sample_t           mem [DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       cnt_q;
  logic              pop_en, push_en;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);
  assign dout    = mem[rd_q];

  // Pointers wrap naturally; count tracks occupancy 0..DEPTH.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_en) wr_q <= wr_q + 1'b1;
      if (pop_en)  rd_q <= rd_q + 1'b1;
      case ({push_en, pop_en})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array; contents are meaningless while empty, so no reset.
  always_ff @(posedge CLOCK_50) begin
    if (push_en) mem[wr_q] <= din;
  end
endmodule

// File: rtl/mix_output_stage.sv
// Mixer output stage: attenuate, saturate to 16 bits, buffer, and hand
// mono samples to the codec with a write/allowed handshake. Also drives a
// clip LED with hold timer and a saturating overrun counter.
module mix_output_stage
  import audio_pkg::*;
#(
  parameter int IN_W       = MIX_W,
  parameter int FIFO_DEPTH = 8,
  parameter int CLIP_HOLD  = 5000000
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic [IN_W-1:0]    mix_in,
  input  logic               mix_valid,
  input  logic [1:0]         atten,
  input  logic               audio_out_allowed,
  output logic               write_audio_out,
  output logic [CODEC_W-1:0] left_channel_audio_out,
  output logic [CODEC_W-1:0] right_channel_audio_out,
  output logic               clip_led,
  output logic [7:0]         overrun_count
);
  localparam int TW = $clog2(CLIP_HOLD + 1);
  localparam logic signed [IN_W-1:0] POS_LIM = IN_W'(32'sd32767);
  localparam logic signed [IN_W-1:0] NEG_LIM = IN_W'(-32'sd32768);

  logic signed [IN_W-1:0] s1_q;
  logic                   v1_q, v2_q;
  sample_t                smp2_q, smp2_d;
  logic                   clip2_q, clip2_d;
  logic [TW-1:0]          tmr_q;
  logic                   led_q;
  logic                   wr_q;
  logic [CODEC_W-1:0]     chan_q;
  logic [7:0]             ovr_q;

  sample_t fifo_dout;
  logic    fifo_full, fifo_empty, pop, push, overrun;

  // Stage 1: arithmetic right shift keeps the sign of the mix sum.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      s1_q <= '0;
      v1_q <= 1'b0;
    end else begin
      s1_q <= $signed(mix_in) >>> atten;
      v1_q <= mix_valid;
    end
  end

  // Clamp the scaled value into the signed 16-bit sample range.
  always_comb begin
    smp2_d  = s1_q[SAMPLE_W-1:0];
    clip2_d = 1'b0;
    if (s1_q > POS_LIM) begin
      smp2_d  = SAT_MAX;
      clip2_d = 1'b1;
    end else if (s1_q < NEG_LIM) begin
      smp2_d  = SAT_MIN;
      clip2_d = 1'b1;
    end
  end

  // Stage 2: register the saturated sample and its clip flag.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      smp2_q  <= '0;
      clip2_q <= 1'b0;
      v2_q    <= 1'b0;
    end else begin
      smp2_q  <= smp2_d;
      clip2_q <= clip2_d;
      v2_q    <= v1_q;
    end
  end

  // Pop depends only on registered occupancy, so a fresh push into an
  // empty FIFO can never be popped in the same cycle.
  assign pop     = !fifo_empty && audio_out_allowed;
  assign push    = v2_q && (!fifo_full || pop);
  assign overrun = v2_q && fifo_full && !pop;

  sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .push     (push),
    .pop      (pop),
    .din      (smp2_q),
    .dout     (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Clip hold timer: every clip reloads, otherwise count down to zero.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      tmr_q <= '0;
      led_q <= 1'b0;
    end else begin
      if (v2_q && clip2_q)  tmr_q <= TW'(CLIP_HOLD - 1);
      else if (tmr_q != '0) tmr_q <= tmr_q - 1'b1;
      led_q <= (tmr_q != '0);
    end
  end

  // Codec handshake: one write strobe per pop; channel data holds between.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      wr_q   <= 1'b0;
      chan_q <= '0;
    end else begin
      wr_q <= pop;
      if (pop) chan_q <= {fifo_dout, 16'h0000};
    end
  end

  // Dropped-sample counter, sticks at 255.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)                      ovr_q <= '0;
    else if (overrun && ovr_q != 8'hFF) ovr_q <= ovr_q + 1'b1;
  end

  assign write_audio_out         = wr_q;
  assign left_channel_audio_out  = chan_q;
  assign right_channel_audio_out = chan_q;
  assign clip_led                = led_q;
  assign overrun_count           = ovr_q;
endmodule

// File: tb/tb_mix_output_stage.sv
// Bench for mix_output_stage: directed scenarios plus a random run, all
// compared against a queue-based behavioural model of the output stage.
module tb_mix_output_stage;
  localparam int H = 16;

  logic        CLOCK_50 = 1'b0;
  logic        resetn   = 1'b0;
  logic [18:0] mix_in   = '0;
  logic        mix_valid = 1'b0;
  logic [1:0]  atten    = '0;
  logic        audio_out_allowed = 1'b0;
  logic        write_audio_out;
  logic [31:0] left_channel_audio_out, right_channel_audio_out;
  logic        clip_led;
  logic [7:0]  overrun_count;

  mix_output_stage #(.IN_W(19), .FIFO_DEPTH(8), .CLIP_HOLD(H)) dut (
    .CLOCK_50                (CLOCK_50),
    .resetn                  (resetn),
    .mix_in                  (mix_in),
    .mix_valid               (mix_valid),
    .atten                   (atten),
    .audio_out_allowed       (audio_out_allowed),
    .write_audio_out         (write_audio_out),
    .left_channel_audio_out  (left_channel_audio_out),
    .right_channel_audio_out (right_channel_audio_out),
    .clip_led                (clip_led),
    .overrun_count           (overrun_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_fail   = 0;

  // ---- behavioural model ----
  typedef struct { int due; logic [15:0] smp; bit clip; } pend_t;
  pend_t       pq[$];
  logic [15:0] mq[$];
  int          ecount = 0;
  int          last_clip = -1000, prev_clip = -1000;
  bit          exp_write = 0;
  logic [31:0] exp_data = '0;
  int          exp_ovr = 0;
  bit          exp_led = 0;

  function automatic bit in_win(int e, int c);
    return (e - c >= 1) && (e - c <= H - 1);
  endfunction

  task automatic model_reset();
    pq.delete(); mq.delete();
    last_clip = -1000; prev_clip = -1000;
    exp_write = 0; exp_data = '0; exp_ovr = 0; exp_led = 0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, and
  // return at the following negedge ready for sampling.
  task automatic step(input bit v, input int val, input int a, input bit al);
    int s, d; bit pop; pend_t it; int pre;
    mix_valid = v; mix_in = val[18:0]; atten = a[1:0]; audio_out_allowed = al;
    @(posedge CLOCK_50);
    ecount++;
    pre = mq.size();
    pop = (pre > 0) && al;
    exp_write = pop;
    if (pop) begin exp_data = {mq[0], 16'h0000}; void'(mq.pop_front()); end
    if (pq.size() > 0 && pq[0].due == ecount) begin
      it = pq.pop_front();
      if (it.clip) begin prev_clip = last_clip; last_clip = ecount; end
      if (pre < 8 || pop) mq.push_back(it.smp);
      else if (exp_ovr < 255) exp_ovr++;
    end
    if (v) begin
      d = 1 << a;
      s = (val >= 0) ? val / d : -((-val + d - 1) / d);
      it.due = ecount + 2;
      if (s > 32767)       begin it.smp = 16'h7FFF; it.clip = 1; end
      else if (s < -32768) begin it.smp = 16'h8000; it.clip = 1; end
      else                 begin it.smp = s[15:0];  it.clip = 0; end
      pq.push_back(it);
    end
    exp_led = in_win(ecount, last_clip) || in_win(ecount, prev_clip);
    @(negedge CLOCK_50);
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    #1;
    n_checks++; if (write_audio_out !== 1'b0) begin n_fail++; $display("FAIL reset_write got %b exp 0", write_audio_out); end
    n_checks++; if (left_channel_audio_out !== 32'h0 || right_channel_audio_out !== 32'h0) begin n_fail++; $display("FAIL reset_chan got %h/%h exp 0", left_channel_audio_out, right_channel_audio_out); end
    n_checks++; if (clip_led !== 1'b0 || overrun_count !== 8'h0) begin n_fail++; $display("FAIL reset_led_ovr got %b/%0d exp 0/0", clip_led, overrun_count); end
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_passthrough();
    step(1, 256, 0, 1);
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 0, 1);
      n_checks++; if (write_audio_out !== (i == 3)) begin n_fail++; $display("FAIL pass_write cyc%0d got %b exp %b", i, write_audio_out, (i == 3)); end
    end
    n_checks++; if (left_channel_audio_out !== 32'h0100_0000 || right_channel_audio_out !== 32'h0100_0000) begin n_fail++; $display("FAIL pass_data got %h/%h exp 01000000", left_channel_audio_out, right_channel_audio_out); end
    n_checks++; if (clip_led !== 1'b0) begin n_fail++; $display("FAIL pass_led got %b exp 0", clip_led); end
  endtask

  task automatic test_saturation();
    step(1, 40000, 0, 1);
    step(1, -40000, 0, 1);
    for (int i = 2; i <= 26; i++) begin
      step(0, 0, 0, 1);
      if (i == 3) begin
        n_checks++; if (write_audio_out !== 1'b1 || left_channel_audio_out !== 32'h7FFF_0000) begin n_fail++; $display("FAIL sat_pos got %b %h exp 1 7fff0000", write_audio_out, left_channel_audio_out); end
        n_checks++; if (clip_led !== 1'b1) begin n_fail++; $display("FAIL sat_led_rise got %b exp 1", clip_led); end
      end
      if (i == 4) begin
        n_checks++; if (write_audio_out !== 1'b1 || right_channel_audio_out !== 32'h8000_0000) begin n_fail++; $display("FAIL sat_neg got %b %h exp 1 80000000", write_audio_out, right_channel_audio_out); end
      end
      n_checks++; if (clip_led !== exp_led) begin n_fail++; $display("FAIL sat_led cyc%0d got %b exp %b", i, clip_led, exp_led); end
    end
    n_checks++; if (clip_led !== 1'b0) begin n_fail++; $display("FAIL sat_led_off got %b exp 0", clip_led); end
  endtask

  task automatic test_atten();
    step(1, 40000, 3, 1);
    step(1, -5, 1, 1);
    for (int i = 2; i <= 5; i++) begin
      step(0, 0, 0, 1);
      if (i == 3) begin n_checks++; if (left_channel_audio_out !== 32'h1388_0000) begin n_fail++; $display("FAIL atten3 got %h exp 13880000", left_channel_audio_out); end end
      if (i == 4) begin n_checks++; if (left_channel_audio_out !== 32'hFFFD_0000) begin n_fail++; $display("FAIL atten1 got %h exp fffd0000", left_channel_audio_out); end end
      n_checks++; if (clip_led !== 1'b0) begin n_fail++; $display("FAIL atten_led cyc%0d got %b exp 0", i, clip_led); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] got[$];
    for (int i = 1; i <= 13; i++) begin
      step(i <= 10, i, 0, 0);
      n_checks++; if (write_audio_out !== 1'b0) begin n_fail++; $display("FAIL ovf_nowrite cyc%0d got %b exp 0", i, write_audio_out); end
    end
    n_checks++; if (overrun_count !== 8'd2) begin n_fail++; $display("FAIL ovf_count got %0d exp 2", overrun_count); end
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 1);
      if (write_audio_out === 1'b1) got.push_back(left_channel_audio_out);
    end
    n_checks++; if (got.size() != 8) begin n_fail++; $display("FAIL ovf_pulses got %0d exp 8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      n_checks++; if (got[i] !== {16'(i + 1), 16'h0000}) begin n_fail++; $display("FAIL ovf_order[%0d] got %h exp %h", i, got[i], {16'(i + 1), 16'h0000}); end
    end
  endtask

  task automatic test_full_pushpop();
    logic [31:0] got[$];
    // ninth sample reaches the FIFO on the same edge as the first pop
    for (int i = 0; i < 9; i++) step(1, 101 + i, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 1);
      if (write_audio_out === 1'b1) got.push_back(left_channel_audio_out);
    end
    n_checks++; if (overrun_count !== 8'd2) begin n_fail++; $display("FAIL full_ovr got %0d exp 2", overrun_count); end
    n_checks++; if (got.size() != 9) begin n_fail++; $display("FAIL full_pulses got %0d exp 9", got.size()); end
    for (int i = 0; i < got.size() && i < 9; i++) begin
      n_checks++; if (got[i] !== {16'(101 + i), 16'h0000}) begin n_fail++; $display("FAIL full_order[%0d] got %h exp %h", i, got[i], {16'(101 + i), 16'h0000}); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(9) < 6, int'($urandom_range(524286)) - 262143,
           int'($urandom_range(3)), $urandom_range(1) == 1);
      n_checks++; if (write_audio_out !== exp_write) begin n_fail++; $display("FAIL rnd_write cyc%0d got %b exp %b", i, write_audio_out, exp_write); end
      n_checks++; if (left_channel_audio_out !== exp_data || right_channel_audio_out !== exp_data) begin n_fail++; $display("FAIL rnd_data cyc%0d got %h/%h exp %h", i, left_channel_audio_out, right_channel_audio_out, exp_data); end
      n_checks++; if (clip_led !== exp_led) begin n_fail++; $display("FAIL rnd_led cyc%0d got %b exp %b", i, clip_led, exp_led); end
      n_checks++; if (overrun_count !== 8'(exp_ovr)) begin n_fail++; $display("FAIL rnd_ovr cyc%0d got %0d exp %0d", i, overrun_count, exp_ovr); end
    end
  endtask

  task automatic test_reset_midstream();
    step(1, 40000, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 11 + i, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    #1 resetn = 1'b0;
    #1;
    n_checks++; if (write_audio_out !== 1'b0 || left_channel_audio_out !== 32'h0 || right_channel_audio_out !== 32'h0) begin n_fail++; $display("FAIL mid_reset_out got %b %h/%h exp 0", write_audio_out, left_channel_audio_out, right_channel_audio_out); end
    n_checks++; if (clip_led !== 1'b0 || overrun_count !== 8'h0) begin n_fail++; $display("FAIL mid_reset_led_ovr got %b/%0d exp 0/0", clip_led, overrun_count); end
    model_reset();
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 1);
      n_checks++; if (write_audio_out !== 1'b0) begin n_fail++; $display("FAIL mid_post_write cyc%0d got %b exp 0", i, write_audio_out); end
    end
    step(1, 77, 0, 1);
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 0, 1);
      n_checks++; if (write_audio_out !== exp_write || left_channel_audio_out !== exp_data) begin n_fail++; $display("FAIL mid_new cyc%0d got %b %h exp %b %h", i, write_audio_out, left_channel_audio_out, exp_write, exp_data); end
      if (i == 3) begin n_checks++; if (left_channel_audio_out !== 32'h004D_0000) begin n_fail++; $display("FAIL mid_new_data got %h exp 004d0000", left_channel_audio_out); end end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_saturation();
    test_atten();
    test_overflow();
    test_full_pushpop();
    test_random();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
